// File: rtl/shift_add_mul4_pkg.sv
// Shared constants for the 4x4 shift-and-add multiplier.
// Holds the operand width, the iteration count, the counter value that marks
// the final iteration, and the FSM state encoding. The RTL and the testbench
// both import this package.
package shift_add_mul4_pkg;

  localparam int OP_WIDTH   = 4;
  localparam int PROD_WIDTH = 2 * OP_WIDTH;
  localparam int ITER       = 4;

  // Counter value seen during the last RUN cycle (a 2-bit counter, 0..3).
  localparam logic [1:0] ITER_LAST = 2'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul4_if.sv
// Request/result bundle for shift_add_mul4.
//   start    : request, honoured only while the multiplier is idle
//   a, b     : multiplicand and multiplier, captured when start is accepted
//   busy     : high while the multiplication is iterating
//   done     : one-cycle pulse when p/overflow carry a new product
//   p        : unsigned product a*b
//   overflow : product does not fit in 4 bits (p[7:4] != 0)
// The master drives the request; the slave (the multiplier) drives the result.
interface shift_add_mul4_if;

  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;
  logic       overflow;

  modport master (
    output start, a, b,
    input  busy, done, p, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, p, overflow
  );

endinterface

// File: rtl/shift_add_mul4_adder4.sv
// 4-bit ripple adder that the multiplier reuses for its partial-product
// accumulation.
//   sum      : 4-bit sum of a + b + cin
//   overflow : carry-out of the addition
//   a, b     : 4-bit addends
//   cin      : carry-in
module shift_add_mul4_adder4 (
  output logic [3:0] sum,
  output logic       overflow,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {4'd0, cin};

endmodule

// File: rtl/shift_add_mul4.sv
// Sequential 4x4 unsigned multiplier using the shift-and-add method.
// Once start is accepted in IDLE it runs four RUN cycles, one per multiplier
// bit, then spends one cycle in DONE with done high. The product and the
// overflow flag are held until the next product completes.
//   clk : system clock, all state changes on its rising edge
//   rst : synchronous active-high reset, overrides everything else
//   bus : request/result bundle (start, a, b in; busy, done, p, overflow out)
module shift_add_mul4
  import shift_add_mul4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_add_mul4_if.slave     bus
);

  if (WIDTH != OP_WIDTH) begin : g_width_check
    $error("shift_add_mul4: only WIDTH=4 is supported");
  end

  state_t     state_r;
  state_t     state_next_s;
  logic       accept_s;
  logic       last_iter_s;

  logic [3:0] m_r;
  logic [3:0] hi_r;
  logic [3:0] lo_r;
  logic [1:0] cnt_r;
  logic [7:0] p_r;
  logic       ovf_r;
  logic       busy_r;
  logic       done_r;

  logic [3:0] addend_s;
  logic [3:0] sum_s;
  logic       carry_s;
  logic [3:0] hi_shift_s;
  logic [3:0] lo_shift_s;

  assign last_iter_s = (cnt_r == ITER_LAST);

  // Adding zero when lo[0]=0 yields {0,hi}, so one adder covers both cases.
  always_comb begin
    addend_s = 4'd0;
    if (lo_r[0]) begin
      addend_s = m_r;
    end else begin
      addend_s = 4'd0;
    end
  end

  shift_add_mul4_adder4 u_adder (
    .sum      (sum_s),
    .overflow (carry_s),
    .a        (hi_r),
    .b        (addend_s),
    .cin      (1'b0)
  );

  // {carry,sum,lo} >> 1: the carry-out lands in hi[3], sum[0] drops into lo[3].
  assign hi_shift_s = {carry_s, sum_s[3:1]};
  assign lo_shift_s = {sum_s[0], lo_r[3:1]};

  // Next-state decode and the accept strobe for a new request.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_iter_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand capture, shift-add iteration and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r   <= 4'd0;
      hi_r  <= 4'd0;
      lo_r  <= 4'd0;
      cnt_r <= 2'd0;
      p_r   <= 8'd0;
      ovf_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            m_r   <= bus.a;
            hi_r  <= 4'd0;
            lo_r  <= bus.b;
            cnt_r <= 2'd0;
          end
        end
        RUN: begin
          hi_r  <= hi_shift_s;
          lo_r  <= lo_shift_s;
          cnt_r <= cnt_r + 2'd1;
          if (last_iter_s) begin
            p_r   <= {hi_shift_s, lo_shift_s};
            ovf_r <= |hi_shift_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.p        = p_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_shift_add_mul4.sv
// Self-checking bench for shift_add_mul4. Expected products come from plain
// integer multiplication; expected timing comes from the protocol: accept at
// edge k, busy during the four following cycles, done for exactly one cycle
// after edge k+4, product held at all other times.
module tb_shift_add_mul4;
  import shift_add_mul4_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] last_p;
  logic       last_ovf;
  int         order[256];

  shift_add_mul4_if bus ();

  shift_add_mul4 #(.WIDTH(OP_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle. With hold=1, start stays high
  // with other operands during RUN and DONE; those requests must be ignored.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit hold);
    int prod;
    prod = int'(a) * int'(b);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus.a = 4'd1;
      bus.b = 4'd1;
    end else begin
      bus.start = 1'b0;
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
    end
    for (int j = 0; j < ITER; j++) begin
      check("busy_run", {7'd0, bus.busy}, 8'd1);
      check("done_run", {7'd0, bus.done}, 8'd0);
      check("p_hold", bus.p, last_p);
      check("ovf_hold", {7'd0, bus.overflow}, {7'd0, last_ovf});
      @(posedge clk);
      @(negedge clk);
    end
    last_p   = prod[7:0];
    last_ovf = (prod > 15);
    check("done_pulse", {7'd0, bus.done}, 8'd1);
    check("busy_done", {7'd0, bus.busy}, 8'd0);
    check("product", bus.p, last_p);
    check("overflow", {7'd0, bus.overflow}, {7'd0, last_ovf});
    @(posedge clk);
    @(negedge clk);
    check("done_end", {7'd0, bus.done}, 8'd0);
    check("busy_idle", {7'd0, bus.busy}, 8'd0);
    check("p_after", bus.p, last_p);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_p = 8'd0;
    last_ovf = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 4'd0;
    bus.b = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    check("rst_done", {7'd0, bus.done}, 8'd0);
    check("rst_p", bus.p, 8'h00);
    check("rst_ovf", {7'd0, bus.overflow}, 8'd0);

    // Directed products.
    run_op(4'd9, 4'd12, 1'b0);
    run_op(4'd3, 4'd5, 1'b0);
    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd0, 4'd13, 1'b0);

    // start held through RUN/DONE: only one done, next op on first IDLE edge.
    run_op(4'd6, 4'd7, 1'b1);
    run_op(4'd1, 4'd1, 1'b0);

    // Reset on the 2nd RUN edge aborts the operation.
    bus.a = 4'd9;
    bus.b = 4'd12;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_p = 8'd0;
    last_ovf = 1'b0;
    check("abort_busy", {7'd0, bus.busy}, 8'd0);
    check("abort_p", bus.p, 8'h00);
    check("abort_ovf", {7'd0, bus.overflow}, 8'd0);
    for (int j = 0; j < 6; j++) begin
      check("abort_no_done", {7'd0, bus.done}, 8'd0);
      @(posedge clk);
      @(negedge clk);
    end
    run_op(4'd2, 4'd8, 1'b0);

    // Every operand pair, in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(32'(i), 32'd0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(order[i]);
      run_op(v[7:4], v[3:0], 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mul4.md
SHIFT_ADD_MUL4 -- requirements
Module: shift_add_mul4

Interface
REQ-001 SHALL have one parameter: WIDTH, default 4, operand width. WIDTH=4 is the only supported value; any other value SHALL be an elaboration error.
REQ-002 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-003 SHALL have port: clk  input  1  system clock.
REQ-004 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port: start  input  1  request; sampled only when busy=0 and done=0.
REQ-006 SHALL have port: a  input  4  multiplicand, captured on the accepting edge.
REQ-007 SHALL have port: b  input  4  multiplier, captured on the accepting edge.
REQ-008 SHALL have port: busy  output  1  high while in RUN.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when the product is valid.
REQ-010 SHALL have port: p  output  8  unsigned product a*b.
REQ-011 SHALL have port: overflow  output  1  high when p[7:4] != 0, i.e. the product does not fit in 4 bits.

Function
REQ-012 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE, with state encodings IDLE=0, RUN=1, DONE=2.
REQ-013 IDLE: on start=1, SHALL latch M=a, clear hi[3:0] and carry, load lo=b, clear the 2-bit iteration counter, and go to RUN.
REQ-014 RUN, each edge: if lo[0]=1, SHALL compute {c,sum}=hi+M through the 4-bit adder with cin=0; otherwise {c,sum}={0,hi}.
REQ-015 RUN, same edge: SHALL shift the 9-bit value {c,sum,lo} right by one, giving hi=({c,sum,lo}>>1)[7:4] and lo=({c,sum,lo}>>1)[3:0], and increment the counter.
REQ-016 SHALL run exactly 4 RUN iterations; on the 4th, SHALL load p={hi,lo} (the shifted result) and overflow, then go to DONE.
REQ-017 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+4 and low otherwise.
REQ-018 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-019 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-020 start during RUN or DONE SHALL be ignored, with no queuing and no effect on the in-flight product.
REQ-021 p and overflow SHALL hold their last values until the next product completes; they SHALL NOT change during RUN.
REQ-022 Operand changes on a/b after acceptance SHALL have no effect on the result.
REQ-023 Arithmetic SHALL be unsigned: the adder carry-out feeds the shift, and no carry is lost, so the maximum result is 15*15=225.

Reset
REQ-024 rst=1 at an edge SHALL force state=IDLE, busy=0, done=0, p=0, overflow=0, and counter=0, clearing hi, lo, M and carry.
REQ-025 rst SHALL take priority over start and over any RUN/DONE activity.
REQ-026 Reset mid-RUN SHALL abort the operation with no done pulse.

Structure
REQ-027 The state encodings, WIDTH=4, and ITER=4 SHALL live in a shared constants include file used by RTL and bench.
REQ-028 The addition SHALL be done by one instance of the team's existing 4-bit adder (sum, overflow/carry-out, a, b, cin), with cin tied to 0; there SHALL be no other sub-modules.

Verification
REQ-029 Reset, then idle for 3 cycles -> busy=0, done=0, p=0x00, overflow=0.
REQ-030 a=9, b=12, start for 1 cycle -> done pulses exactly 4 cycles after the accepting edge, p=0x6C (108), overflow=1.
REQ-031 a=3, b=5 -> p=0x0F, overflow=0; then a=15, b=15 -> p=0xE1 (225), overflow=1; then a=0, b=13 -> p=0x00, overflow=0.
REQ-032 a=6, b=7 started, then start held high with a=1, b=1 during RUN -> p=0x2A (42); a single done pulse, with a new operation accepted only on the first edge back in IDLE.
REQ-033 a=9, b=12 started, rst asserted on the 2nd RUN edge -> no done pulse, p=0, then a fresh a=2, b=8 -> p=0x10, overflow=1.
REQ-034 Randomised sweep over all 256 operand pairs -> p equals a*b and overflow equals (a*b>15).
